// File: rtl/game_pkg.sv
// Shared types, default constants and saturating HP helpers for the HP event arbiter.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    INVULN = 2'd1,
    DEAD   = 2'd2
  } hp_state_t;

  localparam int HP_MAX_DEF       = 9;
  localparam int INVULN_TICKS_DEF = 50_000_000;
  localparam int REGEN_TICKS_DEF  = 200_000_000;

  // hp + amt, clamped to max
  function automatic int sat_add(input int hp, input int amt, input int max);
    int s;
    s = hp + amt;
    return (s > max) ? max : s;
  endfunction

  // hp - amt, floored at zero and never above max
  function automatic int sat_sub(input int hp, input int amt, input int max);
    int s;
    s = (hp > amt) ? (hp - amt) : 0;
    return (s > max) ? max : s;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot picker. The search starts at the source after the last
// one granted; the pointer only moves when the caller consumes the pick.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant_oh
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] idx;
  logic          found;

  // Rotating priority search from ptr_q; next pointer is one past the winner
  always_comb begin
    grant_oh = '0;
    ptr_d    = ptr_q;
    idx      = '0;
    found    = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(ptr_q) + k) % N);
      if (!found && req[idx]) begin
        found         = 1'b1;
        grant_oh[idx] = 1'b1;
        ptr_d         = PW'((int'(idx) + 1) % N);
      end
    end
    if (!advance) ptr_d = ptr_q;
  end

  // Pointer register
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/hp_event_arbiter.sv
// Player hit-point scheduler: round-robin grant of damage/heal requests,
// saturating HP arithmetic, post-hit invulnerability window and game-over state.
// Optional build macro HP_REGEN_EN adds slow +1 HP regeneration while idle.
module hp_event_arbiter
  import game_pkg::*;
#(
  parameter int N_SRC        = 4,
  parameter int HP_W         = 4,
  parameter int HP_MAX       = HP_MAX_DEF,
  parameter int INVULN_TICKS = INVULN_TICKS_DEF,
  parameter int REGEN_TICKS  = REGEN_TICKS_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_SRC-1:0]      req,
  input  logic [N_SRC-1:0]      is_heal,
  input  logic [N_SRC*HP_W-1:0] amt,
  input  logic                  restart,
  output logic [N_SRC-1:0]      grant,
  output logic [HP_W-1:0]       hp_numb,
  output logic                  invuln,
  output logic                  dmg_blocked,
  output logic                  game_over
);

  localparam int              TW         = (INVULN_TICKS > 1) ? $clog2(INVULN_TICKS) : 1;
  localparam logic [TW-1:0]   INV_LAST   = TW'(INVULN_TICKS - 1);
  localparam logic [HP_W-1:0] HP_MAX_V   = HP_W'(HP_MAX);

  hp_state_t        state_q, state_d;
  logic [HP_W-1:0]  hp_q, hp_d;
  logic [N_SRC-1:0] grant_q, grant_d;
  logic             blk_q, blk_d;
  logic             inv_q, inv_d;
  logic             go_q, go_d;
  logic [TW-1:0]    timer_q, timer_d;

`ifdef HP_REGEN_EN
  localparam int            RW       = (REGEN_TICKS > 1) ? $clog2(REGEN_TICKS) : 1;
  localparam logic [RW-1:0] REG_LAST = RW'(REGEN_TICKS - 1);
  logic [RW-1:0] regen_q, regen_d;
`endif

  logic [N_SRC-1:0] pick;
  logic             advance;
  logic [HP_W-1:0]  sel_amt;
  logic             sel_heal;

  // restart also rewinds the round-robin pointer
  rr_arbiter #(.N(N_SRC)) u_rr (
    .clk      (clk),
    .rst      (rst | restart),
    .req      (req),
    .advance  (advance),
    .grant_oh (pick)
  );

  // Mux out the kind and amount of the source currently picked
  always_comb begin
    sel_amt  = '0;
    sel_heal = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      if (pick[i]) begin
        sel_amt  = amt[i*HP_W +: HP_W];
        sel_heal = is_heal[i];
      end
    end
  end

  // Next-state, HP update and grant decision; restart overrides everything
  always_comb begin
    state_d = state_q;
    hp_d    = hp_q;
    grant_d = '0;
    blk_d   = 1'b0;
    timer_d = '0;
    advance = 1'b0;
    if (restart) begin
      hp_d    = HP_MAX_V;
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (|req) begin
            advance = 1'b1;
            grant_d = pick;
            if (sel_heal) begin
              hp_d = HP_W'(sat_add(int'(hp_q), int'(sel_amt), HP_MAX));
            end else if (sel_amt != '0) begin
              hp_d = HP_W'(sat_sub(int'(hp_q), int'(sel_amt), HP_MAX));
              if (hp_d == '0) state_d = DEAD;
              else            state_d = INVULN;
            end
          end
        end
        INVULN: begin
          // Blocked hits do not touch the timer, so the window is never extended
          timer_d = timer_q + 1'b1;
          if (timer_q == INV_LAST) begin
            state_d = IDLE;
            timer_d = '0;
          end
          if (|req) begin
            advance = 1'b1;
            grant_d = pick;
            if (sel_heal) hp_d  = HP_W'(sat_add(int'(hp_q), int'(sel_amt), HP_MAX));
            else          blk_d = 1'b1;
          end
        end
        DEAD: begin
          // Requests stall until restart; HP is already zero
        end
        default: state_d = IDLE;
      endcase
    end
`ifdef HP_REGEN_EN
    // Regen runs only while idle and below max; applied damage or a heal on the tick cycle eats the tick
    regen_d = '0;
    if (!restart && state_q == IDLE && hp_q < HP_MAX_V &&
        !(advance && !sel_heal && sel_amt != '0)) begin
      if (regen_q == REG_LAST) begin
        if (!(advance && sel_heal)) hp_d = HP_W'(sat_add(int'(hp_q), 1, HP_MAX));
      end else begin
        regen_d = regen_q + 1'b1;
      end
    end
`endif
    inv_d = (state_d == INVULN);
    go_d  = (state_d == DEAD);
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hp_q    <= HP_MAX_V;
      grant_q <= '0;
      blk_q   <= 1'b0;
      inv_q   <= 1'b0;
      go_q    <= 1'b0;
      timer_q <= '0;
`ifdef HP_REGEN_EN
      regen_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      hp_q    <= hp_d;
      grant_q <= grant_d;
      blk_q   <= blk_d;
      inv_q   <= inv_d;
      go_q    <= go_d;
      timer_q <= timer_d;
`ifdef HP_REGEN_EN
      regen_q <= regen_d;
`endif
    end
  end

  assign grant       = grant_q;
  assign hp_numb     = hp_q;
  assign invuln      = inv_q;
  assign dmg_blocked = blk_q;
  assign game_over   = go_q;

endmodule

// File: tb/tb_hp_event_arbiter.sv
// Self-checking bench for hp_event_arbiter: directed scenarios followed by
// randomized traffic, all compared cycle by cycle against a behavioural model.
module tb_hp_event_arbiter;

  localparam int N   = 4;
  localparam int HW  = 4;
  localparam int HPM = 9;
  localparam int INV = 8;
  localparam int REG = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            restart = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N-1:0]    is_heal = '0;
  logic [N*HW-1:0] amt = '0;
  logic [N-1:0]    grant;
  logic [HW-1:0]   hp_numb;
  logic            invuln;
  logic            dmg_blocked;
  logic            game_over;

  hp_event_arbiter #(
    .N_SRC(N), .HP_W(HW), .HP_MAX(HPM), .INVULN_TICKS(INV), .REGEN_TICKS(REG)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .is_heal(is_heal), .amt(amt),
    .restart(restart), .grant(grant), .hp_numb(hp_numb), .invuln(invuln),
    .dmg_blocked(dmg_blocked), .game_over(game_over)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model: HP value, remaining invulnerable cycles, dead flag,
  // last granted source and cycles spent toward the next regen point.
  int m_hp, m_inv_left, m_last, m_regen;
  bit m_dead;
  int e_grant;
  bit e_blk;

  task automatic model_step();
    int g, a, hp0;
    bit h, was_inv, was_dead, dmg_applied;
    e_grant = -1;
    e_blk   = 1'b0;
    if (rst || restart) begin
      m_hp = HPM; m_inv_left = 0; m_dead = 1'b0; m_last = N - 1; m_regen = 0;
      return;
    end
    was_inv  = (m_inv_left > 0);
    was_dead = m_dead;
    if (was_inv) m_inv_left--;
    hp0 = m_hp;
    dmg_applied = 1'b0;
    h = 1'b0;
    g = -1;
    if (!m_dead) begin
      for (int k = 1; k <= N; k++) begin
        int idx;
        idx = (m_last + k) % N;
        if (g < 0 && req[idx]) g = idx;
      end
    end
    if (g >= 0) begin
      m_last  = g;
      e_grant = g;
      a = int'(amt[g*HW +: HW]);
      h = is_heal[g];
      if (h) begin
        m_hp = (m_hp + a > HPM) ? HPM : m_hp + a;
      end else if (was_inv) begin
        e_blk = 1'b1;
      end else if (a > 0) begin
        m_hp = (m_hp > a) ? m_hp - a : 0;
        dmg_applied = 1'b1;
        if (m_hp == 0) m_dead = 1'b1;
        else           m_inv_left = INV;
      end
    end
`ifdef HP_REGEN_EN
    if (!was_dead && !was_inv && hp0 < HPM && !dmg_applied) begin
      m_regen++;
      if (m_regen == REG) begin
        m_regen = 0;
        if (!(g >= 0 && h)) m_hp = (m_hp + 1 > HPM) ? HPM : m_hp + 1;
      end
    end else begin
      m_regen = 0;
    end
`else
    if (dmg_applied && hp0 < 0) m_regen = 0;
`endif
  endtask

  task automatic cycle();
    logic [N-1:0] eg;
    model_step();
    @(posedge clk);
    #1;
    eg = (e_grant >= 0) ? (N'(1) << e_grant) : '0;
    check_val("grant", grant, eg);
    check_val("hp", hp_numb, m_hp);
    check_val("invuln", invuln, m_inv_left > 0);
    check_val("dmg_blocked", dmg_blocked, e_blk);
    check_val("game_over", game_over, m_dead);
  endtask

  task automatic set_src(input int i, input bit heal, input int a);
    req[i]           = 1'b1;
    is_heal[i]       = heal;
    amt[i*HW +: HW]  = HW'(a);
  endtask

  task automatic wait_vuln();
    for (int i = 0; i < 2 * INV && invuln; i++) cycle();
    check_val("invuln_ends", invuln, 0);
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    cycle();
    cycle();
    check_val("rst_hp", hp_numb, HPM);
    check_val("rst_grant", grant, 0);
    rst = 1'b0;

    // Single damage from source 1
    set_src(1, 1'b0, 3);
    cycle();
    check_val("t1_grant", grant, 4'b0010);
    check_val("t1_hp", hp_numb, 6);
    req = '0;
    wait_vuln();

    // All sources heal at once, served one per cycle, HP saturates
    for (int i = 0; i < N; i++) set_src(i, 1'b1, 1);
    for (int i = 0; i < 2 * N && req != '0; i++) begin
      cycle();
      req &= ~grant;
    end
    check_val("t2_req_drained", req, 0);
    check_val("t2_hp", hp_numb, HPM);

    // Damage blocked during the invulnerable window
    set_src(3, 1'b0, 1);
    cycle();
    req = '0;
    check_val("t3_hp_hit", hp_numb, 8);
    set_src(2, 1'b0, 5);
    cycle();
    req = '0;
    check_val("t3_grant", grant, 4'b0100);
    check_val("t3_blocked", dmg_blocked, 1);
    check_val("t3_hp", hp_numb, 8);
    wait_vuln();

    // Death, stalled requests, restart
    set_src(0, 1'b0, 6);
    cycle();
    req = '0;
    check_val("t4_hp2", hp_numb, 2);
    wait_vuln();
    set_src(1, 1'b0, 7);
    cycle();
    req = '0;
    check_val("t4_dead", game_over, 1);
    check_val("t4_hp0", hp_numb, 0);
    for (int i = 0; i < N; i++) set_src(i, 1'b0, 1);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check_val("t4_stall", grant, 0);
    end

    // Restart beats a simultaneous request
    req = '0;
    set_src(0, 1'b1, 1);
    restart = 1'b1;
    cycle();
    restart = 1'b0;
    check_val("t5_nogrant", grant, 0);
    check_val("t5_hp", hp_numb, HPM);
    check_val("t5_alive", game_over, 0);
    cycle();
    req = '0;
    check_val("t5_grant", grant, 4'b0001);

`ifdef HP_REGEN_EN
    // Regeneration while idle
    set_src(2, 1'b0, 2);
    cycle();
    req = '0;
    wait_vuln();
    for (int i = 0; i < 3 * REG; i++) cycle();
    check_val("t6_hp", hp_numb, HPM);
`endif

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (grant[i]) begin
          req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(0, 3) == 0) begin
          set_src(i, ($urandom_range(0, 2) == 0), int'($urandom_range(0, 5)));
        end
      end
      restart = ($urandom_range(0, 49) == 0);
      rst     = ($urandom_range(0, 499) == 0);
      cycle();
    end
    restart = 1'b0;
    rst     = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
